countdown_ctrl: RTL and testbench

- Sequencing controller for the 4-digit 7-segment display path of the countdown timer.
- Holds an MM:SS countdown as four BCD digits and runs a SET/RUN/PAUSE/DONE state machine from button pulses.
- Drives the display's digit_3..digit_0 values and enable_3..enable_0 lines, including leading-zero blanking and a blink in PAUSE/DONE.
- Drives the alarm output.

---
 rtl/countdown_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// MM:SS countdown sequencer for a 4-digit 7-segment display. Runs SET/RUN/PAUSE/DONE
// from button pulses, drives BCD digits with leading-zero blanking, blink and alarm.
module countdown_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESET_MIN    = 1,
  parameter int PRESET_SEC    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] digit_3,
  output logic [3:0] digit_2,
  output logic [3:0] digit_1,
  output logic [3:0] digit_0,
  output logic       enable_3,
  output logic       enable_2,
  output logic       enable_1,
  output logic       enable_0,
  output logic       alarm
);

  typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam int             PW     = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]  P_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0]  B_LAST = PW'(TICKS_PER_SEC / 2 - 1);
  localparam logic [15:0]    PRESET_TIME = {4'(PRESET_MIN / 10), 4'(PRESET_MIN % 10),
                                            4'(PRESET_SEC / 10), 4'(PRESET_SEC % 10)};

  // Time is packed {min tens, min ones, sec tens, sec ones}.
  state_t        r_state;
  logic [15:0]   r_time;
  logic [15:0]   r_prog;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] r_blink_cnt;
  logic          r_phase;

  state_t        w_state_nx;
  logic [15:0]   w_time_nx;
  logic [15:0]   w_prog_nx;
  logic [PW-1:0] w_presc_nx;
  logic          w_tick;
  logic [15:0]   w_dec;

  // BCD +1 on a 00..59 pair, wrapping 59 to 00.
  function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {(v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // One-second decrement with the full borrow chain.
  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign w_tick = (r_state == S_RUN) && (r_presc == P_LAST);
  assign w_dec  = dec_time(r_time);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    w_state_nx = r_state;
    w_time_nx  = r_time;
    w_prog_nx  = r_prog;
    w_presc_nx = r_presc;
    case (r_state)
      S_SET: begin
        if (btn_clear) begin
          w_time_nx = r_prog;
        end else if (btn_start) begin
          if (r_time != 16'h0000) begin
            w_prog_nx  = r_time;
            w_presc_nx = '0;
            w_state_nx = S_RUN;
          end
        end else begin
          if (inc_min) w_time_nx[15:8] = bcd_inc59(r_time[15:8]);
          if (inc_sec) w_time_nx[7:0]  = bcd_inc59(r_time[7:0]);
        end
      end
      S_RUN: begin
        w_presc_nx = w_tick ? '0 : r_presc + PW'(1);
        if (btn_clear) begin
          w_time_nx  = r_prog;
          w_state_nx = S_SET;
        end else if (w_tick) begin
          w_time_nx = w_dec;
          if (w_dec == 16'h0000) w_state_nx = S_DONE;
          else if (btn_start)    w_state_nx = S_PAUSE;
        end else if (btn_start) begin
          w_state_nx = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (btn_clear) begin
          w_time_nx  = r_prog;
          w_state_nx = S_SET;
        end else if (btn_start) begin
          w_state_nx = S_RUN;
        end
      end
      S_DONE: begin
        if (btn_start || btn_clear) begin
          w_time_nx  = r_prog;
          w_state_nx = S_SET;
        end
      end
      default: w_state_nx = S_SET;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SET;
      r_time  <= PRESET_TIME;
      r_prog  <= PRESET_TIME;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nx;
      r_time  <= w_time_nx;
      r_prog  <= w_prog_nx;
      r_presc <= w_presc_nx;
    end
  end

  // Blink restarts dark on every entry into PAUSE or DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_state_nx == S_PAUSE || w_state_nx == S_DONE) begin
      if (w_state_nx != r_state) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (r_blink_cnt == B_LAST) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + PW'(1);
      end
    end else begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end
  end

  assign digit_3  = r_time[15:12];
  assign digit_2  = r_time[11:8];
  assign digit_1  = r_time[7:4];
  assign digit_0  = r_time[3:0];
  assign enable_3 = r_phase && (r_time[15:12] != 4'd0);
  assign enable_2 = r_phase;
  assign enable_1 = r_phase;
  assign enable_0 = r_phase;
  assign alarm    = (r_state == S_DONE);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus random button traffic,
// compared every cycle against a seconds-based reference model.
module tb_countdown_ctrl;

  localparam int TPS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0, btn_clear = 1'b0, inc_min = 1'b0, inc_sec = 1'b0;
  logic [3:0] digit_3, digit_2, digit_1, digit_0;
  logic enable_3, enable_2, enable_1, enable_0, alarm;

  countdown_ctrl #(.TICKS_PER_SEC(TPS), .PRESET_MIN(0), .PRESET_SEC(3)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
    .inc_min(inc_min), .inc_sec(inc_sec),
    .digit_3(digit_3), .digit_2(digit_2), .digit_1(digit_1), .digit_0(digit_0),
    .enable_3(enable_3), .enable_2(enable_2), .enable_1(enable_1), .enable_0(enable_0),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time as total seconds, age = edges spent in PAUSE/DONE since entry.
  typedef enum {M_SET, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode = M_SET;
  int    m_t = 3, m_prog = 3, m_presc = 0, m_age = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digits_of(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {digit_3, digit_2, digit_1, digit_0};
  endfunction

  task automatic model_update(input logic s, input logic c, input logic im, input logic is,
                              input logic r);
    mode_t prev;
    bit    tick;
    if (r) begin
      m_mode = M_SET; m_t = 3; m_prog = 3; m_presc = 0; m_age = 0;
      return;
    end
    prev = m_mode;
    case (m_mode)
      M_SET: begin
        if (c) m_t = m_prog;
        else if (s) begin
          if (m_t != 0) begin m_prog = m_t; m_presc = 0; m_mode = M_RUN; end
        end else begin
          if (im) m_t = ((m_t / 60 + 1) % 60) * 60 + m_t % 60;
          if (is) m_t = (m_t / 60) * 60 + (m_t % 60 + 1) % 60;
        end
      end
      M_RUN: begin
        tick    = (m_presc == TPS - 1);
        m_presc = tick ? 0 : m_presc + 1;
        if (c) begin m_t = m_prog; m_mode = M_SET; end
        else begin
          if (tick) m_t = m_t - 1;
          if (tick && m_t == 0) m_mode = M_DONE;
          else if (s) m_mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (c) begin m_t = m_prog; m_mode = M_SET; end
        else if (s) m_mode = M_RUN;
      end
      M_DONE: begin
        if (s || c) begin m_t = m_prog; m_mode = M_SET; end
      end
    endcase
    m_age = (m_mode == prev) ? m_age + 1 : 0;
  endtask

  task automatic compare_outputs();
    bit ph;
    ph = 1'b1;
    if (m_mode == M_PAUSE || m_mode == M_DONE) ph = ((m_age / (TPS / 2)) % 2) == 1;
    check("digits", 32'(dut_digits()), 32'(digits_of(m_t)));
    check("enables", {28'd0, enable_3, enable_2, enable_1, enable_0},
          {28'd0, ph && (m_t / 600 != 0), ph, ph, ph});
    check("alarm", 32'(alarm), 32'(m_mode == M_DONE));
  endtask

  task automatic step(input logic s, input logic c, input logic im, input logic is,
                      input logic r);
    btn_start = s; btn_clear = c; inc_min = im; inc_sec = is; rst = r;
    @(posedge clk);
    model_update(s, c, im, is, r);
    #1;
    btn_start = 1'b0; btn_clear = 1'b0; inc_min = 1'b0; inc_sec = 1'b0; rst = 1'b0;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    logic [15:0] frozen;

    // Reset state.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("reset_digits", 32'(dut_digits()), 32'h0003);
    check("reset_enables", {28'd0, enable_3, enable_2, enable_1, enable_0}, 32'h7);
    check("reset_alarm", 32'(alarm), 32'd0);

    // Countdown 00:03 to DONE, then watch the blink and acknowledge.
    step(1, 0, 0, 0, 0);
    idle(12);
    check("done_alarm", 32'(alarm), 32'd1);
    idle(5);
    step(1, 0, 0, 0, 0);
    check("ack_alarm_off", 32'(alarm), 32'd0);

    // Build 10:00 and check the full borrow chain.
    for (int i = 0; i < 57; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
    check("set_10_00", 32'(dut_digits()), 32'h1000);
    step(1, 0, 0, 0, 0);
    idle(4);
    check("borrow_chain", 32'(dut_digits()), 32'h0959);
    check("lead_zero_blank", 32'(enable_3), 32'd0);

    // Pause at prescaler 2, hold, resume and time the next decrement.
    for (int i = 0; i < 8 && m_presc != 2; i++) idle(1);
    check("presc_reached_2", 32'(m_presc), 32'd2);
    step(1, 0, 0, 0, 0);
    frozen = dut_digits();
    idle(20);
    check("pause_frozen", 32'(dut_digits()), 32'(frozen));
    step(1, 0, 0, 0, 0);
    k = 1;
    while (k < 8 && dut_digits() == frozen) begin
      idle(1);
      k++;
    end
    check("resume_delay", 32'(k), 32'd2);

    // Clear back to 10:00, then wrap tests on the seconds and minutes pairs.
    step(0, 1, 0, 0, 0);
    check("clear_to_prog", 32'(dut_digits()), 32'h1000);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 0, 0, 1, 0);
    check("sec_wrap_no_carry", 32'(dut_digits()), 32'h0000);
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0);
    check("min_59", 32'(dut_digits()), 32'h5900);
    step(0, 0, 1, 0, 0);
    check("min_wrap", 32'(dut_digits()), 32'h0000);

    // Start at 00:00 is ignored; still in SET, so inc_sec is honoured next.
    step(1, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 1, 0);
    check("start_at_zero_stays_set", 32'(dut_digits()), 32'h0001);

    // Start and clear together during RUN.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    idle(6);
    step(1, 1, 0, 0, 0);
    check("start_clear_to_prog", 32'(dut_digits()), 32'h0005);

    // Reset mid-RUN.
    step(1, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 1);
    check("rst_mid_run_digits", 32'(dut_digits()), 32'h0003);
    check("rst_mid_run_alarm", 32'(alarm), 32'd0);

    // Random button traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 999) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
